// File: rtl/vdiv_element_sequencer.sv
// Issue-side element sequencer for the per-lane vector divider.
// Walks elements vstart..vl-1 of one divide/remainder instruction: reads
// operands, drives the divider start/done handshake, writes each result
// back and signals instruction completion to the lane controller.
module vdiv_element_sequencer #(
    parameter int VLMAX = 32,
    parameter int IDX_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W:0]   req_vl,
    input  logic [IDX_W-1:0] req_vstart,
    input  logic             req_signed,
    input  logic             req_quot,
    input  logic             req_mask_en,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_en,
    input  logic [31:0]      rd_vs1,
    input  logic [31:0]      rd_vs2,
    input  logic             rd_mask,
    output logic             start_div,
    output logic [31:0]      vs1_data,
    output logic [31:0]      vs2_data,
    output logic             is_signed_div,
    output logic             div_type,
    input  logic             busy_du,
    input  logic             done_du,
    input  logic [31:0]      wdata_du,
    input  logic             exception_du,
    output logic             stop_flush,
    output logic             decode_done,
    output logic             wb_en,
    output logic [IDX_W-1:0] wb_idx,
    output logic [31:0]      wb_data,
    input  logic             flush,
    output logic             instr_done,
    output logic             dz_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_FIN
    } state_t;

    localparam logic [IDX_W:0] VL_MAX = (IDX_W+1)'(VLMAX);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   vl_q, vl_d;
    logic             signed_q, signed_d;
    logic             quot_q, quot_d;
    logic             mask_en_q, mask_en_d;
    logic             start_div_q, start_div_d;
    logic [31:0]      vs1_q, vs1_d;
    logic [31:0]      vs2_q, vs2_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             dz_q, dz_d;
    logic             last_elem;

    // The divider's busy line is not needed for sequencing; done_du alone
    // marks completion.
    logic unused_busy;
    assign unused_busy = busy_du;

    // Compare in IDX_W+1 bits so idx == VLMAX-1 never wraps.
    assign last_elem = (({1'b0, idx_q} + (IDX_W+1)'(1)) == vl_q);

    // Next-state, datapath capture and control strobes.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vl_d        = vl_q;
        signed_d    = signed_q;
        quot_d      = quot_q;
        mask_en_d   = mask_en_q;
        start_div_d = start_div_q;
        vs1_d       = vs1_q;
        vs2_d       = vs2_q;
        wb_data_d   = wb_data_q;
        dz_d        = dz_q;
        req_ready   = (state_q == S_IDLE) && !flush;
        rd_en       = 1'b0;
        decode_done = 1'b0;
        wb_en       = 1'b0;
        instr_done  = 1'b0;
        stop_flush  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    vl_d      = (req_vl > VL_MAX) ? VL_MAX : req_vl;
                    idx_d     = req_vstart;
                    signed_d  = req_signed;
                    quot_d    = req_quot;
                    mask_en_d = req_mask_en;
                    dz_d      = 1'b0;
                    state_d   = ({1'b0, req_vstart} >= req_vl) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                rd_en   = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // Operand data and mask arrive the cycle after the read strobe.
                vs1_d       = rd_vs1;
                vs2_d       = rd_vs2;
                decode_done = last_elem;
                if (mask_en_q && !rd_mask) begin
                    if (last_elem) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
                end else begin
                    start_div_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_du) begin
                    start_div_d = 1'b0;
                    wb_data_d   = wdata_du;
                    dz_d        = dz_q | exception_du;
                    state_d     = S_WB;
                end
            end
            S_WB: begin
                wb_en = 1'b1;
                if (last_elem) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_FIN: begin
                instr_done = 1'b1;
                stop_flush = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush aborts from any state and wins over a new request.
        if (flush) begin
            state_d     = S_IDLE;
            start_div_d = 1'b0;
            dz_d        = 1'b0;
            rd_en       = 1'b0;
            wb_en       = 1'b0;
            decode_done = 1'b0;
            instr_done  = 1'b0;
            stop_flush  = 1'b1;
        end
    end

    // State, index, configuration and operand/result registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            vl_q        <= '0;
            signed_q    <= 1'b0;
            quot_q      <= 1'b0;
            mask_en_q   <= 1'b0;
            start_div_q <= 1'b0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            wb_data_q   <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vl_q        <= vl_d;
            signed_q    <= signed_d;
            quot_q      <= quot_d;
            mask_en_q   <= mask_en_d;
            start_div_q <= start_div_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            wb_data_q   <= wb_data_d;
            dz_q        <= dz_d;
        end
    end

    assign rd_idx        = idx_q;
    assign wb_idx        = idx_q;
    assign start_div     = start_div_q && !flush;
    assign vs1_data      = vs1_q;
    assign vs2_data      = vs2_q;
    assign is_signed_div = signed_q;
    assign div_type      = quot_q;
    assign wb_data       = wb_data_q;
    assign dz_flag       = dz_q;

endmodule

// File: tb/tb_vdiv_element_sequencer.sv
// Scoreboard bench for vdiv_element_sequencer: operand file model, divider
// stub with RISC-V divide semantics, and a negedge monitor that pops
// expected writeback / completion events.
module tb_vdiv_element_sequencer;

    localparam int IDX_W = 5;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             req_valid, req_ready;
    logic [IDX_W:0]   req_vl;
    logic [IDX_W-1:0] req_vstart;
    logic             req_signed, req_quot, req_mask_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_en;
    logic [31:0]      rd_vs1, rd_vs2;
    logic             rd_mask;
    logic             start_div;
    logic [31:0]      vs1_data, vs2_data;
    logic             is_signed_div, div_type;
    logic             busy_du, done_du, exception_du;
    logic [31:0]      wdata_du;
    logic             stop_flush, decode_done, wb_en;
    logic [IDX_W-1:0] wb_idx;
    logic [31:0]      wb_data;
    logic             flush, instr_done, dz_flag;

    always #5 CLK = ~CLK;

    vdiv_element_sequencer #(.VLMAX(32), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_vl(req_vl),
        .req_vstart(req_vstart), .req_signed(req_signed), .req_quot(req_quot),
        .req_mask_en(req_mask_en),
        .rd_idx(rd_idx), .rd_en(rd_en), .rd_vs1(rd_vs1), .rd_vs2(rd_vs2),
        .rd_mask(rd_mask),
        .start_div(start_div), .vs1_data(vs1_data), .vs2_data(vs2_data),
        .is_signed_div(is_signed_div), .div_type(div_type),
        .busy_du(busy_du), .done_du(done_du), .wdata_du(wdata_du),
        .exception_du(exception_du),
        .stop_flush(stop_flush), .decode_done(decode_done),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .flush(flush), .instr_done(instr_done), .dz_flag(dz_flag)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Operand register file: data valid the cycle after rd_en.
    logic [31:0] m_vs1 [32];
    logic [31:0] m_vs2 [32];
    logic        m_mask[32];

    always @(posedge CLK) begin
        if (rd_en) begin
            rd_vs1  <= m_vs1[rd_idx];
            rd_vs2  <= m_vs2[rd_idx];
            rd_mask <= m_mask[rd_idx];
        end
    end

    // Divider stub with RISC-V semantics, fixed latency.
    function automatic logic [31:0] divf(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn, input logic quot);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0)                                  return quot ? 32'hFFFF_FFFF : a;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return quot ? a : 32'd0;
        if (sgn)                                         return quot ? 32'(sa / sb) : 32'(sa % sb);
        return quot ? a / b : a % b;
    endfunction

    int dv_cnt;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_du      <= 1'b0;
            done_du      <= 1'b0;
            wdata_du     <= '0;
            exception_du <= 1'b0;
            dv_cnt       <= 0;
        end else begin
            done_du      <= 1'b0;
            exception_du <= 1'b0;
            if (flush) begin
                busy_du <= 1'b0;
            end else if (busy_du) begin
                if (dv_cnt == 0) begin
                    busy_du      <= 1'b0;
                    done_du      <= 1'b1;
                    wdata_du     <= divf(vs2_data, vs1_data, is_signed_div, div_type);
                    exception_du <= (vs1_data == 32'd0);
                end else begin
                    dv_cnt <= dv_cnt - 1;
                end
            end else if (start_div && !done_du) begin
                busy_du <= 1'b1;
                dv_cnt  <= 2;
            end
        end
    end

    // Scoreboard of expected events: kind 0 = writeback, 1 = instr_done.
    typedef struct {
        bit          kind;
        logic [4:0]  idx;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_wb(input logic [4:0] i, input logic [31:0] d);
        ev_t e;
        e.kind = 1'b0; e.idx = i; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic dz);
        ev_t e;
        e.kind = 1'b1; e.idx = '0; e.data = {31'd0, dz};
        exp_q.push_back(e);
    endtask

    int   cnt_rd, cnt_start, cnt_dd, done_cnt;
    logic [4:0] last_dd_idx;
    logic prev_start;

    // Monitor: pops and compares whenever the DUT presents an event.
    always @(negedge CLK) begin
        if (nRST) begin
            ev_t e;
            if (rd_en) cnt_rd++;
            if (start_div && !prev_start) cnt_start++;
            prev_start = start_div;
            if (decode_done) begin
                cnt_dd++;
                last_dd_idx = rd_idx;
            end
            if (done_du) chk("start_div_held_at_done", {31'd0, start_div}, 32'd1);
            if (wb_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_kind", {31'd0, e.kind}, 32'd0);
                    chk("wb_idx", {27'd0, wb_idx}, {27'd0, e.idx});
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (instr_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", {31'd0, e.kind}, 32'd1);
                    chk("done_dz_flag", {31'd0, dz_flag}, e.data);
                    chk("done_stop_flush", {31'd0, stop_flush}, 32'd1);
                end
            end
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic clr_counts();
        cnt_rd = 0; cnt_start = 0; cnt_dd = 0; last_dd_idx = '1;
    endtask

    task automatic issue(input int vl, input int vstart, input logic sgn,
                         input logic quot, input logic men);
        int t;
        t = 0;
        @(negedge CLK);
        while (!req_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        req_vl      = (IDX_W+1)'(vl);
        req_vstart  = IDX_W'(vstart);
        req_signed  = sgn;
        req_quot    = quot;
        req_mask_en = men;
        req_valid   = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        @(negedge CLK);
        while (!(exp_q.size() == 0 && req_ready) && t < 500) begin
            @(negedge CLK);
            t++;
        end
        chk(nm, exp_q.size(), 32'd0);
    endtask

    task automatic load_t1();
        m_vs2[0] = 100; m_vs2[1] = 7; m_vs2[2] = 9; m_vs2[3] = 0;
        m_vs1[0] = 3;   m_vs1[1] = 2; m_vs1[2] = 9; m_vs1[3] = 5;
        for (int i = 0; i < 32; i++) m_mask[i] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        nRST = 1'b0; req_valid = 1'b0; req_vl = '0; req_vstart = '0;
        req_signed = 1'b0; req_quot = 1'b0; req_mask_en = 1'b0; flush = 1'b0;
        rd_vs1 = '0; rd_vs2 = '0; rd_mask = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_vs1[i] = 32'd1; m_vs2[i] = 32'd0; m_mask[i] = 1'b1;
        end
        clr_counts();
        done_cnt = 0;

        // Reset state
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_start_div", {31'd0, start_div}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_instr_done", {31'd0, instr_done}, 32'd0);
        chk("rst_dz_flag", {31'd0, dz_flag}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // 1: unsigned quotient, four elements
        load_t1();
        clr_counts();
        push_wb(0, 33); push_wb(1, 3); push_wb(2, 1); push_wb(3, 0); push_done(1'b0);
        issue(4, 0, 1'b0, 1'b1, 1'b0);
        wait_idle("t1_drain");
        chk("t1_rd_count", cnt_rd, 4);
        chk("t1_start_count", cnt_start, 4);
        chk("t1_decode_done_count", cnt_dd, 1);
        chk("t1_decode_done_idx", {27'd0, last_dd_idx}, 32'd3);

        // 2: signed remainder overflow case
        m_vs2[0] = 32'h8000_0000; m_vs1[0] = 32'hFFFF_FFFF;
        clr_counts();
        push_wb(0, 32'd0); push_done(1'b0);
        issue(1, 0, 1'b1, 1'b0, 1'b0);
        wait_idle("t2_drain");
        chk("t2_start_count", cnt_start, 1);

        // 3: divide by zero at element 1
        m_vs2[0] = 20; m_vs2[1] = 5; m_vs2[2] = 9;
        m_vs1[0] = 4;  m_vs1[1] = 0; m_vs1[2] = 3;
        push_wb(0, 5); push_wb(1, 32'hFFFF_FFFF); push_wb(2, 3); push_done(1'b1);
        issue(3, 0, 1'b0, 1'b1, 1'b0);
        wait_idle("t3_drain");
        repeat (3) @(negedge CLK);
        chk("t3_dz_sticky_idle", {31'd0, dz_flag}, 32'd1);

        // 4: masked elements 1 and 3 skipped
        m_vs2[0] = 50; m_vs2[1] = 60; m_vs2[2] = 70; m_vs2[3] = 80;
        m_vs1[0] = 5;  m_vs1[1] = 6;  m_vs1[2] = 7;  m_vs1[3] = 8;
        m_mask[0] = 1'b1; m_mask[1] = 1'b0; m_mask[2] = 1'b1; m_mask[3] = 1'b0;
        clr_counts();
        push_wb(0, 10); push_wb(2, 10); push_done(1'b0);
        issue(4, 0, 1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        chk("t4_dz_cleared_on_accept", {31'd0, dz_flag}, 32'd0);
        wait_idle("t4_drain");
        chk("t4_rd_count", cnt_rd, 4);
        chk("t4_start_count", cnt_start, 2);
        chk("t4_decode_done_count", cnt_dd, 1);
        chk("t4_decode_done_idx", {27'd0, last_dd_idx}, 32'd3);

        // 5: vstart == vl, no elements
        for (int i = 0; i < 32; i++) m_mask[i] = 1'b1;
        clr_counts();
        push_done(1'b0);
        issue(5, 5, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t5_done_one_cycle", {31'd0, instr_done}, 32'd1);
        wait_idle("t5_drain");
        chk("t5_rd_count", cnt_rd, 0);
        chk("t5_start_count", cnt_start, 0);

        // 6: flush during WAIT of element 2
        load_t1();
        clr_counts();
        push_wb(0, 33); push_wb(1, 3);
        dc = done_cnt;
        issue(4, 0, 1'b0, 1'b1, 1'b0);
        begin
            int t;
            t = 0;
            @(negedge CLK);
            while (!(start_div && rd_idx == 5'd2) && t < 300) begin
                @(negedge CLK);
                t++;
            end
            chk("t6_reach_wait_elem2", {31'd0, start_div}, 32'd1);
        end
        @(posedge CLK);
        #1 flush = 1'b1;
        @(negedge CLK);
        chk("t6_start_div_gated", {31'd0, start_div}, 32'd0);
        chk("t6_stop_flush", {31'd0, stop_flush}, 32'd1);
        chk("t6_wb_en_gated", {31'd0, wb_en}, 32'd0);
        @(posedge CLK);
        #1 flush = 1'b0;
        repeat (10) @(negedge CLK);
        chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_dz_cleared", {31'd0, dz_flag}, 32'd0);
        chk("t6_no_instr_done", done_cnt, dc);
        chk("t6_queue_empty", exp_q.size(), 32'd0);

        // 6b: next request after flush runs normally
        clr_counts();
        push_wb(0, 33); push_wb(1, 3); push_wb(2, 1); push_wb(3, 0); push_done(1'b0);
        issue(4, 0, 1'b0, 1'b1, 1'b0);
        wait_idle("t6b_drain");
        chk("t6b_start_count", cnt_start, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
